elastic_pipe: RTL and testbench
===============================

Name: elastic_pipe

Overview:
- Parametrised ready/valid pipeline stage chain. It is the next generation of the fixed stall/flush pipeline registers used between the CPU stages.
- It replaces global stall/flush wiring with per-stage valid bits, bubble collapsing and an optional input skid buffer, so `in_ready` can be registered.
- It sits between any producer/consumer pair in the core: fetch→decode, memory request queues, or multi-cycle unit operand buffers.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- STAGES, 2, number of pipeline registers between input and output (≥1).
- SKID, 1, 1 = registered `in_ready` via a one-entry input skid buffer; 0 = combinational `in_ready`.
- CNTW, $clog2(STAGES+2), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of every held entry.
- in_valid  input  1  producer has data.
- in_ready  output  1  block accepts data this cycle.
- in_data  input  WIDTH  producer payload.
- out_valid  output  1  `valid` bit of the last stage.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  WIDTH  payload of the last stage.
- count  output  CNTW  number of valid entries held (stages plus skid).

Behaviour:
- Stages are s[0]..s[STAGES-1]. Each stage has `v[i]` and `d[i]`. `out_valid = v[STAGES-1]`; `out_data = d[STAGES-1]`.
- Per-stage ready (combinational):
  - `r[STAGES] = out_ready`.
  - `r[i] = ~v[i] | r[i+1]`.
  - Bubbles collapse: a stage holding data advances whenever the next stage is empty or draining.
- Advance on a clock edge: if `r[i+1]`, then `v[i+1] <= v[i]` and `d[i+1] <= d[i]`. Otherwise stage i+1 holds.
- Stage 0 loads from source `src`:
  - SKID=1: `src` is the skid entry if `skid_v`, else `in_data`/`in_valid`.
  - SKID=0: `src` is `in_data`/`in_valid`.
- SKID=0:
  - `in_ready = r[0] & ~flush` (combinational from `out_ready`).
- SKID=1:
  - `in_ready = ~skid_v & ~flush`. `skid_v` is a flop, so there is no combinational path from `out_ready`.
  - Accepted data with `r[0]=0` is written to skid (`skid_v <= 1`).
  - When `r[0]=1` and `skid_v`, the skid entry moves to s[0] and `skid_v <= 0`.
  - A new beat cannot arrive in that same cycle because `in_ready` was 0.
  - Ordering is strictly FIFO: skid data always precedes later input.
- Handshake:
  - A transfer occurs when valid & ready in the same cycle.
  - `out_data` and `out_valid` stay stable while `out_valid & ~out_ready`.
  - `in_data` is sampled only on an `in_valid & in_ready` edge.
- Latency and throughput:
  - An accepted beat into an empty pipe appears as `out_valid` exactly STAGES cycles after the acceptance edge (SKID does not add latency when s[0] is free).
  - Sustained throughput is 1 beat/cycle with `out_ready` held at 1.
- `count`:
  - Equals the sum of `v[]` plus `skid_v`, registered with state.
  - Range 0..STAGES+SKID. It never wraps.
- Flush:
  - On an edge with `flush=1`, all `v[]` and `skid_v` are cleared, and the input beat is not accepted (`in_ready=0`).
  - An output beat presented in the flush cycle with `out_ready=1` still counts as transferred.
  - `count=0` on the next cycle.
- Reset:
  - `rst=1` clears all `v[]`, `skid_v` and `count`, and all `d[]` and skid data to 0. Priority: `rst` > `flush` > normal.
  - Out of reset: `out_valid=0`, `out_data=0`, `count=0`; `in_ready=1` (SKID=1) or 1 (SKID=0, pipe empty).
  - Reset mid-transfer discards everything with no partial output.
- Data registers load only when their stage advances, to save power. Payload width passes through unchanged with no transformation.

Test Plan:
- WIDTH=32, STAGES=3, SKID=1, `out_ready=1`, one beat 0xDEADBEEF at cycle 0 → `out_valid=1` with `out_data=0xDEADBEEF` at cycle 3, `count` goes 1,1,1 then 0 after the output transfer.
- Stream 0x1..0x8 back-to-back with `out_ready=1` → output 0x1..0x8 on 8 consecutive cycles, no bubbles, `in_ready` constant 1.
- Fill with `out_ready=0`, `in_valid=1` for 6 cycles → exactly 4 accepted (3 stages + skid), `count=4`, `in_ready=0`. Then `out_ready=1` → data drains in order 1,2,3,4 with no duplication or loss.
- Bubble collapse: accept 0xA, idle 2 cycles, accept 0xB while `out_ready=0` → both held adjacent, `count=2`. Release `out_ready` → 0xA then 0xB on consecutive cycles.
- Flush with `count=3` and `in_valid=1` → `in_ready=0` that cycle, next cycle `count=0` and `out_valid=0`, flushed data never appears, the next accepted beat arrives after 3 cycles.
- Assert `rst` while full and stalled → next cycle `out_valid=0`, `out_data=0`, `count=0`, `in_ready=1`. Repeat the full test with SKID=0, STAGES=1: `in_ready` follows `out_ready` combinationally when full.

Source files
------------

// File: rtl/elastic_pipe.sv
// elastic_pipe: parametrised ready/valid register chain with per-stage valid
// bits, bubble collapsing and an optional one-entry input skid buffer that
// lets in_ready come straight from a flop instead of from out_ready.
module elastic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SKID   = 1,
  parameter int CNTW   = $clog2(STAGES + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count
);

  // Stage state: v_q[i] says stage i holds a beat, d_q[i] is its payload.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [WIDTH-1:0]  d_q [STAGES];

  // r[i]: stage i can take a beat this cycle (empty, or its content leaves).
  logic [STAGES-1:0] r;
  logic              ready_acc;

  // ld[i]: stage i captures a valid beat on this edge (data enable).
  logic [STAGES-1:0] ld;

  // Source feeding stage 0 (skid entry first, otherwise the input port).
  logic              accept;
  logic              src_v;
  logic [WIDTH-1:0]  src_d;
  logic              skid_v_d;

  logic [CNTW-1:0]   count_q;
  logic [CNTW-1:0]   count_d;

  // Ready chain from the output back to stage 0; an empty stage anywhere
  // downstream opens the path, which is what collapses bubbles.
  always_comb begin
    // NOTE: ready_acc is a combinational running term, so blocking '=' is
    // correct here; each iteration must see the value from the previous one.
    ready_acc = out_ready;
    r         = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_acc = ready_acc | ~v_q[i];
      r[i]      = ready_acc;
    end
  end

  assign accept = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_v_q;
      logic [WIDTH-1:0] skid_d_q;

      // in_ready depends only on flops and flush, never on out_ready.
      assign in_ready = ~skid_v_q & ~flush;
      assign src_v    = skid_v_q | accept;
      assign src_d    = skid_v_q ? skid_d_q : in_data;

      // Skid occupancy: park a beat that stage 0 cannot take, release it as
      // soon as stage 0 frees up. No new beat can arrive while it is full.
      always_comb begin
        // NOTE: assigning the hold value first means every path drives
        // skid_v_d, so no latch is inferred.
        skid_v_d = skid_v_q;
        if (flush) begin
          skid_v_d = 1'b0;
        end else if (accept && !r[0]) begin
          skid_v_d = 1'b1;
        end else if (r[0]) begin
          skid_v_d = 1'b0;
        end
      end

      // Skid registers; payload is only written when a beat is parked.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_v_q <= 1'b0;
          skid_d_q <= '0;
        end else begin
          skid_v_q <= skid_v_d;
          if (accept && !r[0]) begin
            skid_d_q <= in_data;
          end
        end
      end
    end else begin : g_noskid
      // Without the skid, in_ready is the combinational stage-0 ready.
      assign in_ready = r[0] & ~flush;
      assign src_v    = accept;
      assign src_d    = in_data;
      assign skid_v_d = 1'b0;
    end
  endgenerate

  // Next-state of the valid bits and per-stage data enables.
  always_comb begin
    v_d = v_q;
    ld  = '0;
    if (r[0]) begin
      v_d[0] = src_v;
      ld[0]  = src_v;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (r[i]) begin
        v_d[i] = v_q[i-1];
        ld[i]  = v_q[i-1];
      end
    end
    // A flush kills every held beat; a beat leaving at the output this
    // cycle has already been handed over and is unaffected.
    if (flush) begin
      v_d = '0;
    end
  end

  // Occupancy after this edge: valid stages plus the skid entry.
  always_comb begin
    count_d = CNTW'(skid_v_d);
    for (int i = 0; i < STAGES; i++) begin
      count_d = count_d + CNTW'(v_d[i]);
    end
  end

  // Control state: valid bits and registered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  // Payload registers load only when a valid beat moves into them.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payloads are cleared on reset so out_data reads 0 afterwards;
      // this is a small register chain, not a RAM, so resetting it is cheap.
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      if (ld[0]) begin
        d_q[0] <= src_d;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (ld[i]) begin
          d_q[i] <= d_q[i-1];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign count     = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: a STAGES=3/SKID=1 instance (a_*) and a
// STAGES=1/SKID=0 instance (b_*) sharing clock and reset.
module tb_elastic_pipe;

  logic        clk;
  logic        rst;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int n_run;
  int n_fail;

  elastic_pipe #(.WIDTH(32), .STAGES(3), .SKID(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
  );

  elastic_pipe #(.WIDTH(32), .STAGES(1), .SKID(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid got %b want 0", a_out_valid); end
    n_run++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_a_out_data got %h want 0", a_out_data); end
    n_run++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_a_count got %0d want 0", a_count); end
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); end
    n_run++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid got %b want 0", b_out_valid); end
    n_run++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready got %b want 1", b_in_ready); end
  endtask

  // One beat into an empty pipe: visible 3 cycles after it was presented.
  task automatic test_latency();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hDEADBEEF;
    #1;
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      logic       exp_v;
      logic [2:0] exp_c;
      exp_v = (c == 3);
      exp_c = (c <= 3) ? 3'd1 : 3'd0;
      n_run++; if (a_out_valid !== exp_v) begin n_fail++; $display("FAIL lat_out_valid cycle %0d got %b want %b", c, a_out_valid, exp_v); end
      n_run++; if (a_count !== exp_c) begin n_fail++; $display("FAIL lat_count cycle %0d got %0d want %0d", c, a_count, exp_c); end
      if (c == 3) begin
        n_run++; if (a_out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat_out_data got %h want deadbeef", a_out_data); end
      end
      tick();
    end
  endtask

  // 0x1..0x8 streamed with out_ready=1: no bubbles, in_ready stays high.
  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        a_in_valid = 1'b1;
        a_in_data  = 32'(c + 1);
      end else begin
        a_in_valid = 1'b0;
        a_in_data  = '0;
      end
      #1;
      if (c < 8) begin
        n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, a_in_ready); end
      end
      if (c >= 3 && c <= 10) begin
        n_run++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'(c - 2)) begin
          n_fail++; $display("FAIL b2b_out cycle %0d got v=%b d=%h want v=1 d=%h", c, a_out_valid, a_out_data, 32'(c - 2));
        end
      end
      if (c == 11) begin
        n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_valid got %b want 0", a_out_valid); end
      end
      tick();
    end
  endtask

  // Stall the output: 3 stages plus skid take 4 beats, then drain in order.
  task automatic test_fill_drain();
    bit [5:0] exp_rdy;
    int       accepted;
    exp_rdy  = 6'b001111;
    accepted = 0;
    a_out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(c + 1);
      #1;
      n_run++; if (a_in_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL fill_in_ready cycle %0d got %b want %b", c, a_in_ready, exp_rdy[c]); end
      if (a_in_ready === 1'b1) accepted++;
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    n_run++; if (accepted != 4) begin n_fail++; $display("FAIL fill_accepted got %0d want 4", accepted); end
    n_run++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", a_count); end
    n_run++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready_full got %b want 0", a_in_ready); end
    a_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) begin
        n_run++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'(c + 1)) begin
          n_fail++; $display("FAIL drain_out beat %0d got v=%b d=%h want v=1 d=%h", c, a_out_valid, a_out_data, 32'(c + 1));
        end
      end else begin
        n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_tail_valid got %b want 0", a_out_valid); end
        n_run++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", a_count); end
      end
      tick();
    end
  endtask

  // 0xA, two idle cycles, 0xB under stall: both held adjacent, then drain.
  task automatic test_bubble_collapse();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hA;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    a_in_valid = 1'b1;
    a_in_data  = 32'hB;
    #1;
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_in_ready got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    n_run++; if (a_count !== 3'd2) begin n_fail++; $display("FAIL bub_count got %0d want 2", a_count); end
    n_run++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'hA) begin
      n_fail++; $display("FAIL bub_head got v=%b d=%h want v=1 d=a", a_out_valid, a_out_data);
    end
    a_out_ready = 1'b1;
    tick();
    n_run++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin
      n_fail++; $display("FAIL bub_second got v=%b d=%h want v=1 d=b", a_out_valid, a_out_data);
    end
    tick();
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_tail_valid got %b want 0", a_out_valid); end
  endtask

  // Flush with three beats held and a beat offered: everything dropped.
  task automatic test_flush();
    a_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h11 * (c + 1);
      tick();
    end
    a_in_valid = 1'b0;
    n_run++; if (a_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", a_count); end
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 32'h44;
    #1;
    n_run++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", a_in_ready); end
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    n_run++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", a_count); end
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", a_out_valid); end
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h55;
    tick();
    a_in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_run++;
      if (a_out_valid !== (c == 3) || (c == 3 && a_out_data !== 32'h55)) begin
        n_fail++; $display("FAIL flush_after cycle %0d got v=%b d=%h want v=%b d=55", c, a_out_valid, a_out_data, (c == 3));
      end
      tick();
    end
  endtask

  // Reset while full and stalled.
  task automatic test_reset_full();
    a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hC0 + 32'(c);
      tick();
    end
    a_in_valid = 1'b0;
    n_run++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL rstfull_pre_count got %0d want 4", a_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_out_valid got %b want 0", a_out_valid); end
    n_run++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL rstfull_out_data got %h want 0", a_out_data); end
    n_run++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL rstfull_count got %0d want 0", a_count); end
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_in_ready got %b want 1", a_in_ready); end
    tick();
  endtask

  // STAGES=1, SKID=0: in_ready follows out_ready combinationally when full.
  task automatic test_noskid();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 32'h77;
    #1;
    n_run++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_in_ready_empty got %b want 1", b_in_ready); end
    tick();
    b_in_valid = 1'b0;
    #1;
    n_run++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h77) begin
      n_fail++; $display("FAIL ns_out got v=%b d=%h want v=1 d=77", b_out_valid, b_out_data);
    end
    n_run++; if (b_count !== 2'd1) begin n_fail++; $display("FAIL ns_count got %0d want 1", b_count); end
    n_run++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL ns_in_ready_full got %b want 0", b_in_ready); end
    b_out_ready = 1'b1;
    #1;
    n_run++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_in_ready_comb got %b want 1", b_in_ready); end
    b_in_valid = 1'b1;
    b_in_data  = 32'h78;
    tick();
    b_in_valid = 1'b0;
    n_run++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h78) begin
      n_fail++; $display("FAIL ns_next got v=%b d=%h want v=1 d=78", b_out_valid, b_out_data);
    end
    tick();
    n_run++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL ns_tail_valid got %b want 0", b_out_valid); end
    n_run++; if (b_count !== 2'd0) begin n_fail++; $display("FAIL ns_tail_count got %0d want 0", b_count); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_fill_drain();
    test_bubble_collapse();
    test_flush();
    test_reset_full();
    test_noskid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
